// File: rtl/pmem_arb_pkg.sv
// Shared types for the I/D-cache physical-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pmem_arb_pkg;

  // Arbiter FSM states: idle, or one transaction in flight per client.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } arb_state_t;

  // Which client the idle-state arbitration selected this cycle.
  typedef enum logic [1:0] {
    CLI_NONE = 2'd0,
    CLI_D    = 2'd1,
    CLI_I    = 2'd2
  } client_t;

  // Starvation counter width; holds STARVE_LIMIT values 1..15.
  localparam int STARVE_W = 4;

endpackage : pmem_arb_pkg

// File: rtl/pmem_arbiter_fair.sv
// Two-client (D-cache priority, I-cache anti-starvation) arbiter onto one cacheline memory port.
// Latency: memory strobe one cycle after a request is seen in IDLE; client resp is same-cycle with pmem_resp_m.
// Backpressure: a client holds its request until its resp pulse; requests seen while BUSY wait for IDLE.
//
// Ports:
//   clk, rst                        clock, async active-low reset
//   pmem_*_c_d                      D-cache request (read/write, address, wdata) and resp/rdata
//   pmem_*_c_i                      I-cache request (read, address) and resp/rdata
//   pmem_*_m                        registered memory request, memory resp/rdata
//   gnt_d, gnt_i                    which client owns the in-flight transaction
module pmem_arbiter_fair
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] pmem_address_c_d,
  input  logic [LINE_W-1:0] pmem_wdata_c_d,
  input  logic              pmem_read_c_d,
  input  logic              pmem_write_c_d,
  output logic              pmem_resp_c_d,
  output logic [LINE_W-1:0] pmem_rdata_c_d,

  input  logic              pmem_read_c_i,
  input  logic [ADDR_W-1:0] pmem_address_c_i,
  output logic              pmem_resp_c_i,
  output logic [LINE_W-1:0] pmem_rdata_c_i,

  input  logic              pmem_resp_m,
  input  logic [LINE_W-1:0] pmem_rdata_m,
  output logic [ADDR_W-1:0] pmem_address_m,
  output logic [LINE_W-1:0] pmem_wdata_m,
  output logic              pmem_read_m,
  output logic              pmem_write_m,

  output logic              gnt_d,
  output logic              gnt_i
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                read_q, read_d;
  logic                write_q, write_d;

  client_t winner;
  logic    d_req;
  logic    i_req;

  assign d_req = pmem_read_c_d | pmem_write_c_d;
  assign i_req = pmem_read_c_i;

  // State and latched memory request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
    end
  end

  // Arbitration and next-state.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;
    winner   = CLI_NONE;

    case (state_q)
      IDLE: begin
        // A starved I-cache beats the default D-cache priority.
        if (i_req && (starve_q == STARVE_MAX)) begin
          winner = CLI_I;
        end else if (d_req) begin
          winner = CLI_D;
        end else if (i_req) begin
          winner = CLI_I;
        end

        case (winner)
          CLI_D: begin
            state_d = BUSY_D;
            addr_d  = pmem_address_c_d;
            wdata_d = pmem_wdata_c_d;
            // Read+write together is illegal; the write wins so dirty data is never lost.
            write_d = pmem_write_c_d;
            read_d  = pmem_read_c_d & ~pmem_write_c_d;
            if (i_req) begin
              starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
            end else begin
              starve_d = '0;
            end
          end
          CLI_I: begin
            state_d  = BUSY_I;
            addr_d   = pmem_address_c_i;
            wdata_d  = '0;
            read_d   = 1'b1;
            write_d  = 1'b0;
            starve_d = '0;
          end
          default: begin
          end
        endcase
      end

      BUSY_D, BUSY_I: begin
        // Address and data stay latched after completion; only the strobes drop.
        if (pmem_resp_m) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  assign pmem_address_m = addr_q;
  assign pmem_wdata_m   = wdata_q;
  assign pmem_read_m    = read_q;
  assign pmem_write_m   = write_q;

  assign gnt_d = (state_q == BUSY_D);
  assign gnt_i = (state_q == BUSY_I);

  // Completion is passed straight through to the owning client only; the other sees zeros.
  assign pmem_resp_c_d  = gnt_d & pmem_resp_m;
  assign pmem_resp_c_i  = gnt_i & pmem_resp_m;
  assign pmem_rdata_c_d = pmem_resp_c_d ? pmem_rdata_m : '0;
  assign pmem_rdata_c_i = pmem_resp_c_i ? pmem_rdata_m : '0;

`ifndef SYNTHESIS
  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst)
    !(pmem_read_m && pmem_write_m));

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst)
    !(gnt_d && gnt_i));

  // Client protocol violation: reported but not fatal, the write is issued.
  a_d_rw_excl : assert property (@(posedge clk) disable iff (!rst)
    !(pmem_read_c_d && pmem_write_c_d))
    else $warning("pmem_arbiter_fair: D-cache read and write asserted together");
`endif

endmodule : pmem_arbiter_fair
